// File: rtl/calc_job_scheduler_pkg.sv
// rtl/calc_job_scheduler_pkg.sv - shared types and defaults for the calculator job scheduler
package calc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ABORT  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Opcodes understood by the calculator core
  typedef enum logic [2:0] {
    OP_ALU0 = 3'b000,
    OP_ALU1 = 3'b001,
    OP_ALU2 = 3'b010,
    OP_ALU3 = 3'b011,
    OP_DIV  = 3'b100,
    OP_MUL  = 3'b101,
    OP_SEL0 = 3'b110,
    OP_SEL1 = 3'b111
  } opcode_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DW      = 4;
  localparam int DEF_RW      = 8;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/calc_job_scheduler_if.sv
// rtl/calc_job_scheduler_if.sv - requester and calculator-core signal bundle
interface calc_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4,
  parameter int RW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_f;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_result;
  logic               rsp_err;
  logic               busy;
  logic               calc_go;
  logic [2:0]         calc_f;
  logic [DW-1:0]      calc_a;
  logic [DW-1:0]      calc_b;
  logic               calc_done;
  logic [RW-1:0]      calc_result;
  logic               calc_abort;

  modport slave (
    input  req_valid, req_f, req_a, req_b, calc_done, calc_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, busy,
           calc_go, calc_f, calc_a, calc_b, calc_abort
  );

  modport master (
    output req_valid, req_f, req_a, req_b, calc_done, calc_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, busy,
           calc_go, calc_f, calc_a, calc_b, calc_abort
  );
endinterface

// File: rtl/calc_job_scheduler_rr_arbiter.sv
// rtl/calc_job_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  logic [PW:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // One extra bit so ptr+i can exceed NREQ-1 before wrapping
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_job_scheduler.sv
// rtl/calc_job_scheduler.sv - shares one Go/Done calculator core among NREQ requesters
module calc_job_scheduler
  import calc_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int RW      = DEF_RW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  calc_job_scheduler_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, grant, pick_idx;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] pick;
  logic            found;
  logic [2:0]      sel_f;
  logic [DW-1:0]   sel_a, sel_b;

  logic            go_q, abort_q, err_q, busy_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [RW-1:0]   result_q;
  opcode_t         f_q;
  logic [DW-1:0]   a_q, b_q;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .gnt   (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    sel_f    = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        sel_f    = bus.req_f[3*i +: 3];
        sel_a    = bus.req_a[DW*i +: DW];
        sel_b    = bus.req_b[DW*i +: DW];
      end
    end
  end

  always_comb begin
    state_n       = state;
    bus.req_ready = (state == IDLE) ? pick : '0;
    unique case (state)
      IDLE:    if (found) state_n = LAUNCH;
      LAUNCH:  state_n = WAIT;
      // done takes priority over the timeout on the last counted cycle
      WAIT:    if (bus.calc_done) state_n = RESP;
               else if (cnt == CNT_LAST) state_n = ABORT;
      ABORT:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      cnt         <= '0;
      go_q        <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      result_q    <= '0;
      f_q         <= OP_ALU0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state       <= state_n;
      go_q        <= (state_n == LAUNCH);
      abort_q     <= (state_n == ABORT);
      busy_q      <= (state_n != IDLE);
      rsp_valid_q <= '0;
      if (state_n == RESP)
        rsp_valid_q[grant] <= 1'b1;
      unique case (state)
        IDLE: if (found) begin
          grant <= pick_idx;
          f_q   <= opcode_t'(sel_f);
          a_q   <= sel_a;
          b_q   <= sel_b;
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          if (bus.calc_done) begin
            result_q <= bus.calc_result;
            err_q    <= 1'b0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
        RESP: begin
          rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.calc_go    = go_q;
  assign bus.calc_abort = abort_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.calc_f     = f_q;
  assign bus.calc_a     = a_q;
  assign bus.calc_b     = b_q;

endmodule
